// File: rtl/spi_input_controller_adc.sv
// rtl/spi_input_controller_adc.sv - SPI master reading 12-bit samples from a 16-bit-frame serial ADC
//
// Purpose: on an active-low request sampled in IDLE, runs one CS_n-framed,
// CPOL=1 transfer of 16 SCLK periods, captures MISO MSB first, keeps CS_n
// high for QUIET_CYCLES, then presents the low 12 bits with a one-cycle strobe.
//
// Optional feature: SPI_ADC_LEADING_ZERO_CHECK_EN. When defined, frameError
// is the OR of the four leading frame bits, updated with sampleValid. When
// undefined, frameError is tied low.
//
// Ports:
//   clock_50Mhz      system clock
//   reset_n          asynchronous active-low reset
//   startSample_n    active-low sample request, level-sampled in IDLE
//   input_SPI_MISO   serial data from the ADC
//   output_SPI_SCLK  SPI clock, idles high
//   output_SPI_CS_n  ADC chip select, active-low
//   outputSample     last captured 12-bit sample
//   sampleValid      one-cycle pulse when outputSample updates
//   isBusy           high whenever the controller is not idle
//   frameError       leading-zero violation flag

module spi_input_controller_adc #(
    parameter int SCLK_HALF_PERIOD = 2,
    parameter int QUIET_CYCLES     = 4
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic        startSample_n,
    input  logic        input_SPI_MISO,
    output logic        output_SPI_SCLK,
    output logic        output_SPI_CS_n,
    output logic [11:0] outputSample,
    output logic        sampleValid,
    output logic        isBusy,
    output logic        frameError
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_QUIET = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    logic [15:0]      shift;

    // SCLK and CS_n are driven straight from registers, so the registered
    // SCLK level also tells which half of the bit period SHIFT is in.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            output_SPI_SCLK <= 1'b1;
            output_SPI_CS_n <= 1'b1;
            outputSample    <= '0;
            sampleValid     <= 1'b0;
            isBusy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!startSample_n) begin
                        state           <= ST_SETUP;
                        cnt             <= '0;
                        output_SPI_CS_n <= 1'b0;
                        output_SPI_SCLK <= 1'b1;
                        isBusy          <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == HALF_LAST) begin
                        state           <= ST_SHIFT;
                        cnt             <= '0;
                        bit_cnt         <= '0;
                        output_SPI_SCLK <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (!output_SPI_SCLK) begin
                        // Last low-phase cycle: MISO has been stable since the
                        // falling edge, capture it as the rising edge is issued.
                        shift           <= {shift[14:0], input_SPI_MISO};
                        output_SPI_SCLK <= 1'b1;
                        cnt             <= '0;
                    end else begin
                        cnt <= '0;
                        if (bit_cnt == 5'd15) begin
                            state           <= ST_QUIET;
                            output_SPI_CS_n <= 1'b1;
                        end else begin
                            bit_cnt         <= bit_cnt + 1'b1;
                            output_SPI_SCLK <= 1'b0;
                        end
                    end
                end
                ST_QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state        <= ST_DONE;
                        cnt          <= '0;
                        outputSample <= shift[11:0];
                        sampleValid  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    sampleValid <= 1'b0;
                    isBusy      <= 1'b0;
                end
                default: begin
                    state           <= ST_IDLE;
                    cnt             <= '0;
                    output_SPI_SCLK <= 1'b1;
                    output_SPI_CS_n <= 1'b1;
                    sampleValid     <= 1'b0;
                    isBusy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_ADC_LEADING_ZERO_CHECK_EN
    logic frame_error_q;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            frame_error_q <= 1'b0;
        end else if (state == ST_QUIET && cnt == QUIET_LAST) begin
            frame_error_q <= |shift[15:12];
        end
    end

    assign frameError = frame_error_q;
`else
    logic unused_leading_bits;

    assign unused_leading_bits = ^shift[15:12];
    assign frameError          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_input_controller_adc.sv
// tb/tb_spi_input_controller_adc.sv - directed self-checking bench for spi_input_controller_adc

module tb_spi_input_controller_adc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_n;
    logic        miso;
    logic        sclk;
    logic        cs_n;
    logic [11:0] sample;
    logic        valid;
    logic        busy;
    logic        ferr;

    int checks = 0;
    int errors = 0;

    spi_input_controller_adc dut (
        .clock_50Mhz    (clk),
        .reset_n        (reset_n),
        .startSample_n  (start_n),
        .input_SPI_MISO (miso),
        .output_SPI_SCLK(sclk),
        .output_SPI_CS_n(cs_n),
        .outputSample   (sample),
        .sampleValid    (valid),
        .isBusy         (busy),
        .frameError     (ferr)
    );

    always #10 clk = ~clk;

    // ADC model: loads the next frame word when CS_n falls and drives one
    // bit per SCLK falling edge, MSB first.
    logic [15:0] words [4];
    int          widx;
    logic [15:0] cur;
    int          bidx;

    always @(negedge cs_n) begin
        cur  = words[widx];
        widx = (widx + 1) % 4;
        bidx = 15;
    end

    always @(negedge sclk) begin
        if (!cs_n && bidx >= 0) begin
            miso = cur[bidx];
            bidx = bidx - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-run observations, counted in cycles after the request cycle 0.
    int          cs_first, cs_cnt, falls, busy_cnt, nvalid;
    int          vcyc [2];
    logic [11:0] vsmp [2];
    logic        verr [2];

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1);
        words[0] = w0;
        words[1] = w1;
        words[2] = 16'h0000;
        words[3] = 16'h0000;
        widx     = 0;
    endtask

    task automatic run(input int ncyc, input int release_at, input int pulse_at);
        logic prev_sclk;
        cs_first = -1; cs_cnt = 0; falls = 0; busy_cnt = 0; nvalid = 0;
        vcyc[0] = -1; vcyc[1] = -1;
        vsmp[0] = '0; vsmp[1] = '0;
        verr[0] = 1'b0; verr[1] = 1'b0;
        @(negedge clk);
        start_n   = 1'b0;
        prev_sclk = sclk;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == release_at) start_n = 1'b1;
            if (k == pulse_at) start_n = 1'b0;
            if (k == pulse_at + 1) start_n = 1'b1;
            if (!cs_n) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = k;
            end
            if (prev_sclk && !sclk) falls++;
            prev_sclk = sclk;
            if (busy) busy_cnt++;
            if (valid) begin
                if (nvalid < 2) begin
                    vcyc[nvalid] = k;
                    vsmp[nvalid] = sample;
                    verr[nvalid] = ferr;
                end
                nvalid++;
            end
        end
        start_n = 1'b1;
    endtask

    logic exp_lz;

    initial begin
`ifdef SPI_ADC_LEADING_ZERO_CHECK_EN
        exp_lz = 1'b1;
`else
        exp_lz = 1'b0;
`endif
        miso    = 1'b0;
        start_n = 1'b1;
        reset_n = 1'b0;
        load_words(16'h0000, 16'h0000);
        #35;
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sample", 32'(sample), 32'h000);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame
        load_words(16'h0A5F, 16'h0000);
        run(100, 1, -1);
        check("single_cs_first", 32'(cs_first), 32'd1);
        check("single_cs_len", 32'(cs_cnt), 32'd66);
        check("single_falls", 32'(falls), 32'd16);
        check("single_busy_len", 32'(busy_cnt), 32'd71);
        check("single_nvalid", 32'(nvalid), 32'd1);
        check("single_vcyc", 32'(vcyc[0]), 32'd71);
        check("single_sample", 32'(vsmp[0]), 32'hA5F);
        check("single_ferr", 32'(verr[0]), 32'd0);

        // Continuous request: released mid second frame so a third never starts
        load_words(16'h0123, 16'h0FED);
        run(170, 100, -1);
        check("cont_nvalid", 32'(nvalid), 32'd2);
        check("cont_vcyc0", 32'(vcyc[0]), 32'd71);
        check("cont_vcyc1", 32'(vcyc[1]), 32'd143);
        check("cont_sample0", 32'(vsmp[0]), 32'h123);
        check("cont_sample1", 32'(vsmp[1]), 32'hFED);
        check("cont_falls", 32'(falls), 32'd32);

        // Leading-zero violation
        load_words(16'h8FFF, 16'h0000);
        run(90, 1, -1);
        check("lz_nvalid", 32'(nvalid), 32'd1);
        check("lz_sample", 32'(vsmp[0]), 32'hFFF);
        check("lz_ferr", 32'(verr[0]), 32'(exp_lz));

        // Request while busy is ignored
        load_words(16'h0321, 16'h0000);
        run(160, 1, 20);
        check("busy_nvalid", 32'(nvalid), 32'd1);
        check("busy_vcyc", 32'(vcyc[0]), 32'd71);
        check("busy_cs_len", 32'(cs_cnt), 32'd66);
        check("busy_sample", 32'(vsmp[0]), 32'h321);
        check("busy_ferr_cleared", 32'(verr[0]), 32'd0);

        // Reset during bit 7 (low phase spans cycles 31-32)
        load_words(16'h0FFF, 16'h0ABC);
        run(32, 1, -1);
        check("mid_sclk_low", 32'(sclk), 32'd0);
        check("mid_cs_low", 32'(cs_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_sclk", 32'(sclk), 32'd1);
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_sample", 32'(sample), 32'h000);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("mid_no_valid", 32'(nvalid), 32'd0);
        run(90, 1, -1);
        check("mid_next_nvalid", 32'(nvalid), 32'd1);
        check("mid_next_vcyc", 32'(vcyc[0]), 32'd71);
        check("mid_next_sample", 32'(vsmp[0]), 32'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
